// File: rtl/nonce_dispatcher.sv
// Splits a mining job's nonce space into fixed-size batches, hands them to idle
// cores round-robin, latches the first reported hit and flags job completion.
module nonce_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int NONCE_W    = 192,
  parameter int BATCH_LOG2 = 16
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Start_I,
  input  logic                           Stop_I,
  input  logic [NONCE_W-1:0]             NonceBase_I,
  input  logic [31:0]                    BatchLimit_I,
  input  logic [NUM_CORES-1:0]           CoreReq_I,
  input  logic [NUM_CORES-1:0]           CoreFound_I,
  input  logic [NUM_CORES*NONCE_W-1:0]   CoreFoundNonce_I,
  output logic [NUM_CORES-1:0]           CoreGnt_O,
  output logic [NONCE_W-1:0]             CoreNonce_O,
  output logic                           Busy_O,
  output logic                           Found_O,
  output logic [NONCE_W-1:0]             FoundNonce_O,
  output logic [3:0]                     FoundCore_O,
  output logic                           Exhausted_O,
  output logic [31:0]                    BatchCount_O,
  output logic                           Irq_O
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NONCE_W-1:0] STRIDE = NONCE_W'(1) << BATCH_LOG2;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [NONCE_W-1:0]     next_nonce_q, next_nonce_d;
  logic [31:0]            limit_q, limit_d;
  logic [NUM_CORES-1:0]   outstanding_q, outstanding_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic [NONCE_W-1:0]     core_nonce_q, core_nonce_d;
  logic                   found_q, found_d;
  logic [NONCE_W-1:0]     found_nonce_q, found_nonce_d;
  logic [3:0]             found_core_q, found_core_d;
  logic                   exhausted_q, exhausted_d;
  logic [31:0]            batch_count_q, batch_count_d;
  logic                   irq_q, irq_d;

  logic [NUM_CORES-1:0]   eligible;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic                   hit;
  logic [3:0]             hit_idx;
  logic [NONCE_W-1:0]     hit_nonce;

  // Round-robin pick and lowest-index hit selection.
  always_comb begin : select
    int rr_idx;
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    rr_idx     = 0;
    eligible   = CoreReq_I & ~outstanding_q;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NUM_CORES) rr_idx = rr_idx - NUM_CORES;
      if (!pick_valid && eligible[rr_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(rr_idx);
      end
    end

    hit       = |CoreFound_I;
    hit_idx   = '0;
    hit_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (CoreFound_I[i]) begin
        hit_idx   = 4'(i);
        hit_nonce = CoreFoundNonce_I[i*NONCE_W +: NONCE_W];
      end
    end
  end

  always_comb begin : next_state
    state_d       = state_q;
    next_nonce_d  = next_nonce_q;
    limit_d       = limit_q;
    outstanding_d = outstanding_q;
    ptr_d         = ptr_q;
    gnt_d         = '0;
    core_nonce_d  = '0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_core_d  = found_core_q;
    exhausted_d   = exhausted_q;
    batch_count_d = batch_count_q;
    irq_d         = 1'b0;

    if (Start_I) begin
      state_d       = DISPATCH;
      next_nonce_d  = NonceBase_I;
      limit_d       = BatchLimit_I;
      outstanding_d = '0;
      found_d       = 1'b0;
      found_nonce_d = '0;
      found_core_d  = '0;
      exhausted_d   = 1'b0;
      batch_count_d = '0;
    end else if (Stop_I) begin
      state_d = IDLE;
    end else if (state_q == DISPATCH || state_q == DRAIN) begin
      // A requesting core that still holds a batch has just finished it.
      outstanding_d = outstanding_q & ~CoreReq_I;
      if (hit) begin
        found_d       = 1'b1;
        found_nonce_d = hit_nonce;
        found_core_d  = hit_idx;
        state_d       = DONE;
        irq_d         = 1'b1;
      end else if (state_q == DRAIN) begin
        if (outstanding_q == '0) begin
          state_d     = DONE;
          exhausted_d = 1'b1;
          irq_d       = 1'b1;
        end
      end else if (pick_valid) begin
        gnt_d         = NUM_CORES'(1) << pick_idx;
        core_nonce_d  = next_nonce_q;
        outstanding_d = outstanding_d | gnt_d;
        next_nonce_d  = next_nonce_q + STRIDE;
        batch_count_d = batch_count_q + 32'd1;
        ptr_d         = (pick_idx == PTR_W'(NUM_CORES - 1)) ? '0 : pick_idx + PTR_W'(1);
        if (limit_q != '0 && batch_count_d == limit_q) state_d = DRAIN;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      next_nonce_q  <= '0;
      limit_q       <= '0;
      outstanding_q <= '0;
      ptr_q         <= '0;
      gnt_q         <= '0;
      core_nonce_q  <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_core_q  <= '0;
      exhausted_q   <= 1'b0;
      batch_count_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_nonce_q  <= next_nonce_d;
      limit_q       <= limit_d;
      outstanding_q <= outstanding_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      core_nonce_q  <= core_nonce_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_core_q  <= found_core_d;
      exhausted_q   <= exhausted_d;
      batch_count_q <= batch_count_d;
      irq_q         <= irq_d;
    end
  end

  assign CoreGnt_O    = gnt_q;
  assign CoreNonce_O  = core_nonce_q;
  assign Busy_O       = (state_q == DISPATCH) || (state_q == DRAIN);
  assign Found_O      = found_q;
  assign FoundNonce_O = found_nonce_q;
  assign FoundCore_O  = found_core_q;
  assign Exhausted_O  = exhausted_q;
  assign BatchCount_O = batch_count_q;
  assign Irq_O        = irq_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: vector table, hand-written corner sequences and
// randomized traffic against a job-level reference model.
module tb_nonce_dispatcher;

  localparam int N  = 4;
  localparam int NW = 192;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            start, stop;
  logic [NW-1:0]   base;
  logic [31:0]     limit;
  logic [N-1:0]    req, fnd;
  logic [N*NW-1:0] fnonce;

  logic [N-1:0]    gnt;
  logic [NW-1:0]   core_nonce, found_nonce;
  logic            busy, found, exh, irq;
  logic [3:0]      found_core;
  logic [31:0]     cnt;

  nonce_dispatcher #(.NUM_CORES(N), .NONCE_W(NW), .BATCH_LOG2(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start_I(start), .Stop_I(stop),
    .NonceBase_I(base), .BatchLimit_I(limit), .CoreReq_I(req),
    .CoreFound_I(fnd), .CoreFoundNonce_I(fnonce),
    .CoreGnt_O(gnt), .CoreNonce_O(core_nonce), .Busy_O(busy),
    .Found_O(found), .FoundNonce_O(found_nonce), .FoundCore_O(found_core),
    .Exhausted_O(exh), .BatchCount_O(cnt), .Irq_O(irq)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a job is live or not, batches issued are counted, and the
  // batch start is derived arithmetically from the base and the issue count.
  logic          m_live, m_drain;
  int            m_issued, m_rr;
  logic [NW-1:0] m_base;
  logic [31:0]   m_limit;
  logic [N-1:0]  m_pend;
  logic [N-1:0]  e_gnt;
  logic [NW-1:0] e_nonce, e_fnonce;
  logic          e_found, e_exh, e_irq;
  logic [3:0]    e_fcore;

  task automatic model_step();
    logic [N-1:0] held;
    e_gnt = '0; e_nonce = '0; e_irq = 1'b0;
    if (Rst) begin
      m_live = 0; m_drain = 0; m_issued = 0; m_rr = 0; m_base = '0; m_limit = '0;
      m_pend = '0; e_found = 0; e_fnonce = '0; e_fcore = '0; e_exh = 0;
    end else if (start) begin
      m_live = 1; m_drain = 0; m_issued = 0; m_base = base; m_limit = limit;
      m_pend = '0; e_found = 0; e_fnonce = '0; e_fcore = '0; e_exh = 0;
    end else if (stop) begin
      m_live = 0; m_drain = 0;
    end else if (m_live) begin
      held   = m_pend;
      m_pend = m_pend & ~req;
      if (fnd != '0) begin
        for (int i = N - 1; i >= 0; i--)
          if (fnd[i]) begin
            e_fcore  = 4'(i);
            e_fnonce = fnonce[i*NW +: NW];
          end
        e_found = 1; e_irq = 1; m_live = 0; m_drain = 0;
      end else if (m_drain) begin
        if (held == '0) begin
          e_exh = 1; e_irq = 1; m_live = 0; m_drain = 0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (e_gnt == '0 && req[c] && !held[c]) begin
            e_gnt     = N'(1) << c;
            e_nonce   = m_base + (NW'(m_issued) << 16);
            m_pend[c] = 1'b1;
            m_issued++;
            m_rr = (c + 1) % N;
            if (m_limit != 0 && 32'(m_issued) == m_limit) m_drain = 1;
          end
        end
      end
    end
  endtask

  // One clock: DUT and model see the same inputs, outputs are compared #1 later.
  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    check("gnt", gnt, e_gnt);
    if (e_gnt != '0) check("nonce", core_nonce, e_nonce);
    check("busy", busy, m_live);
    check("found", found, e_found);
    check("found_core", found_core, e_fcore);
    check("found_nonce", found_nonce, e_fnonce);
    check("exhausted", exh, e_exh);
    check("batch_count", cnt, m_issued);
    check("irq", irq, e_irq);
  endtask

  typedef struct {
    logic          st, sp;
    logic [NW-1:0] b;
    logic [31:0]   lim;
    logic [N-1:0]  rq, fd;
    logic [N-1:0]  eg;
    logic [NW-1:0] en;
    logic          eb, ef;
    logic [3:0]    efc;
    logic [NW-1:0] efn;
    logic          ex;
    logic [31:0]   ec;
    logic          ei;
  } vec_t;

  vec_t vt[32];
  int   nv = 0;

  task automatic add(input logic st, sp, input logic [NW-1:0] b, input logic [31:0] lim,
                     input logic [N-1:0] rq, fd, eg, input logic [NW-1:0] en,
                     input logic eb, ef, input logic [3:0] efc, input logic [NW-1:0] efn,
                     input logic ex, input logic [31:0] ec, input logic ei);
    vt[nv] = '{st, sp, b, lim, rq, fd, eg, en, eb, ef, efc, efn, ex, ec, ei};
    nv++;
  endtask

  logic [NW-1:0] wrap_base;

  initial begin
    Rst = 1; start = 0; stop = 0; base = '0; limit = '0; req = '0; fnd = '0;
    fnonce = '0;
    fnonce[0*NW +: NW] = NW'('h11);
    fnonce[1*NW +: NW] = NW'('hAA);
    fnonce[2*NW +: NW] = NW'('h22);
    fnonce[3*NW +: NW] = NW'('hBB);

    //   st sp base lim req     fnd     gnt     nonce     busy fnd core fnonce exh cnt irq
    // Four cores all requesting, unlimited job.
    add(1, 0, 'h10, 0, 4'b0000, 4'b0000, 4'b0000, 0,        1, 0, 0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0001, 'h10,     1, 0, 0, 0,    0, 1, 0);
    add(0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0010, 'h10010,  1, 0, 0, 0,    0, 2, 0);
    add(0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0100, 'h20010,  1, 0, 0, 0,    0, 3, 0);
    add(0, 0, 0,    0, 4'b1111, 4'b0000, 4'b1000, 'h30010,  1, 0, 0, 0,    0, 4, 0);
    add(0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0001, 'h40010,  1, 0, 0, 0,    0, 5, 0);
    // Limit of three with cores 0 and 2; pointer continues from core 1.
    add(1, 0, 0,    3, 4'b0000, 4'b0000, 4'b0000, 0,        1, 0, 0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 4'b0101, 4'b0000, 4'b0100, 'h0,      1, 0, 0, 0,    0, 1, 0);
    add(0, 0, 0,    0, 4'b0101, 4'b0000, 4'b0001, 'h10000,  1, 0, 0, 0,    0, 2, 0);
    add(0, 0, 0,    0, 4'b0101, 4'b0000, 4'b0100, 'h20000,  1, 0, 0, 0,    0, 3, 0);
    add(0, 0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 0,        1, 0, 0, 0,    0, 3, 0);
    add(0, 0, 0,    0, 4'b0101, 4'b0000, 4'b0000, 0,        1, 0, 0, 0,    0, 3, 0);
    add(0, 0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 0,        0, 0, 0, 0,    1, 3, 1);
    add(0, 0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 0,        0, 0, 0, 0,    1, 3, 0);
    // Simultaneous hits on cores 1 and 3, then a late hit that must be ignored.
    add(1, 0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 0,        1, 0, 0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 4'b0000, 4'b1010, 4'b0000, 0,        0, 1, 1, 'hAA, 0, 0, 1);
    add(0, 0, 0,    0, 4'b0000, 4'b1000, 4'b0000, 0,        0, 1, 1, 'hAA, 0, 0, 0);
    add(0, 0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 0,        0, 1, 1, 'hAA, 0, 0, 0);

    // Reset state.
    cycle();
    check("rst.busy", busy, 0);
    check("rst.cnt", cnt, 0);
    Rst = 0;

    for (int i = 0; i < nv; i++) begin
      start = vt[i].st; stop = vt[i].sp; base = vt[i].b; limit = vt[i].lim;
      req = vt[i].rq; fnd = vt[i].fd;
      cycle();
      check($sformatf("vec%0d.gnt", i), gnt, vt[i].eg);
      if (vt[i].eg != '0) check($sformatf("vec%0d.nonce", i), core_nonce, vt[i].en);
      check($sformatf("vec%0d.busy", i), busy, vt[i].eb);
      check($sformatf("vec%0d.found", i), found, vt[i].ef);
      check($sformatf("vec%0d.core", i), found_core, vt[i].efc);
      check($sformatf("vec%0d.fnonce", i), found_nonce, vt[i].efn);
      check($sformatf("vec%0d.exh", i), exh, vt[i].ex);
      check($sformatf("vec%0d.cnt", i), cnt, vt[i].ec);
      check($sformatf("vec%0d.irq", i), irq, vt[i].ei);
    end
    start = 0; stop = 0; req = '0; fnd = '0;

    // Nonce wrap at the top of the space, from a fresh reset (pointer 0).
    Rst = 1; cycle(); Rst = 0;
    wrap_base = {NW{1'b1}} << 16;
    start = 1; base = wrap_base; limit = 0; cycle(); start = 0;
    req = 4'b1111; cycle();
    check("wrap.gnt0", gnt, 4'b0001);
    check("wrap.nonce0", core_nonce, wrap_base);
    cycle();
    check("wrap.gnt1", gnt, 4'b0010);
    check("wrap.nonce1", core_nonce, 0);

    // Stop mid-dispatch: idle, no grant, no interrupt.
    stop = 1; cycle(); stop = 0;
    check("stop.busy", busy, 0);
    check("stop.gnt", gnt, 0);
    check("stop.irq", irq, 0);
    cycle();
    check("stop.gnt_after", gnt, 0);
    check("stop.irq_after", irq, 0);

    // Start together with a hit: start wins, nothing is latched.
    req = '0; fnd = 4'b0001; start = 1; cycle(); start = 0; fnd = '0;
    check("startfound.busy", busy, 1);
    check("startfound.found", found, 0);
    check("startfound.irq", irq, 0);
    cycle();
    check("startfound.found_after", found, 0);

    // Reset during DRAIN with cores 0 and 2 both outstanding (pointer at 2).
    start = 1; base = 0; limit = 2; cycle(); start = 0;
    req = 4'b0101; cycle();
    check("drainrst.gnt_a", gnt, 4'b0100);
    req = 4'b0001; cycle();
    check("drainrst.gnt_b", gnt, 4'b0001);
    check("drainrst.cnt", cnt, 2);
    req = '0; cycle();
    check("drainrst.busy_drain", busy, 1);
    Rst = 1; cycle(); Rst = 0;
    check("drainrst.gnt", gnt, 0);
    check("drainrst.nonce", core_nonce, 0);
    check("drainrst.busy", busy, 0);
    check("drainrst.found", found, 0);
    check("drainrst.exh", exh, 0);
    check("drainrst.cnt0", cnt, 0);
    check("drainrst.irq", irq, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("drainrst.irq_later", irq, 0);
    end

    // Randomized traffic against the model.
    start = 1; base = '0; limit = 0; cycle(); start = 0;
    for (int c = 0; c < 4000; c++) begin
      Rst   = ($urandom % 500 == 0);
      start = ($urandom % 50 == 0);
      stop  = ($urandom % 150 == 0);
      if (start) begin
        for (int j = 0; j < NW / 32; j++) base[j*32 +: 32] = $urandom;
        if ($urandom % 3 == 0) base = wrap_base - (NW'($urandom % 4) << 16);
        limit = $urandom % 7;
      end
      req = N'($urandom);
      fnd = ($urandom % 30 == 0) ? N'($urandom) : '0;
      for (int j = 0; j < N * NW / 32; j++) fnonce[j*32 +: 32] = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
